// File: rtl/cve2_fpu_issue_ctrl_pkg.sv
// Shared types for the FPU issue controller: FSM states, status width, writeback tag.
package cve2_fpu_issue_ctrl_pkg;

  localparam int unsigned FPU_FLAGS_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } fpu_ctrl_state_e;

  typedef struct packed {
    logic [4:0] rd;
    logic       rd_fp;
  } fpu_tag_t;

endpackage

// File: rtl/cve2_fpu_issue_ctrl_if.sv
// Handshake bundle between the issue controller (master) and the fpnew instance (slave).
interface cve2_fpu_issue_ctrl_if #(
  parameter int unsigned FlagsW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic              flush;
  logic [31:0]       result;
  logic [FlagsW-1:0] status;

  modport master (
    output in_valid, out_ready, flush,
    input  in_ready, out_valid, result, status
  );

  modport slave (
    input  in_valid, out_ready, flush,
    output in_ready, out_valid, result, status
  );
endinterface

// File: rtl/cve2_fpu_issue_ctrl.sv
// Single-outstanding FP op sequencer: issue to fpnew, wait for result, arbitrate writeback,
// flush/watchdog abort and sticky fflags accumulation.
module cve2_fpu_issue_ctrl
  import cve2_fpu_issue_ctrl_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 64,
  parameter int unsigned FlagsW        = FPU_FLAGS_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [4:0]            req_rd_i,
  input  logic                  req_rd_fp_i,
  input  logic                  flush_i,

  cve2_fpu_issue_ctrl_if.master fpu,

  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [4:0]            wb_rd_o,
  output logic                  wb_rd_fp_o,
  output logic [31:0]           wb_data_o,

  output logic [FlagsW-1:0]     fflags_o,
  input  logic                  fflags_clr_i,
  output logic                  busy_o,
  output logic                  timeout_o
);

  localparam bit          WdEn = (TimeoutCycles != 0);
  localparam int unsigned CntW = WdEn ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = WdEn ? CntW'(TimeoutCycles - 1) : '0;

  fpu_ctrl_state_e   state_q, state_d;
  fpu_tag_t          tag_q, tag_d;
  logic [31:0]       res_q, res_d;
  logic [FlagsW-1:0] sts_q, sts_d;
  logic [FlagsW-1:0] fflags_q, fflags_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      tag_q    <= '0;
      res_q    <= '0;
      sts_q    <= '0;
      fflags_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      res_q    <= res_d;
      sts_q    <= sts_d;
      fflags_q <= fflags_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tag_d         = tag_q;
    res_d         = res_q;
    sts_d         = sts_q;
    cnt_d         = cnt_q;
    // A CSR clear always applies; an accepted writeback ORs on top of the cleared value.
    fflags_d      = fflags_clr_i ? '0 : fflags_q;
    req_ready_o   = 1'b0;
    fpu.in_valid  = 1'b0;
    fpu.out_ready = 1'b0;
    fpu.flush     = 1'b0;
    wb_valid_o    = 1'b0;
    timeout_o     = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_o = !flush_i;
        if (req_valid_i && !flush_i) begin
          tag_d   = '{rd: req_rd_i, rd_fp: req_rd_fp_i};
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        fpu.in_valid  = 1'b1;
        fpu.out_ready = 1'b1;
        if (flush_i) begin
          fpu.flush = 1'b1;
          state_d   = IDLE;
        end else if (fpu.in_ready) begin
          cnt_d = '0;
          if (fpu.out_valid) begin
            res_d   = fpu.result;
            sts_d   = fpu.status;
            state_d = WB;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        fpu.out_ready = 1'b1;
        if (flush_i) begin
          fpu.flush = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (fpu.out_valid) begin
          res_d   = fpu.result;
          sts_d   = fpu.status;
          cnt_d   = '0;
          state_d = WB;
        end else if (WdEn && cnt_q == CntLast) begin
          timeout_o = 1'b1;
          fpu.flush = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WB: begin
        wb_valid_o = 1'b1;
        if (flush_i) begin
          state_d = IDLE;
        end else if (wb_ready_i) begin
          fflags_d = fflags_d | sts_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_rd_o    = tag_q.rd;
  assign wb_rd_fp_o = tag_q.rd_fp;
  assign wb_data_o  = res_q;
  assign fflags_o   = fflags_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_cve2_fpu_issue_ctrl.sv
// Scoreboarded bench for the FPU issue controller; a second instance exercises a short watchdog.
module tb_cve2_fpu_issue_ctrl;
  import cve2_fpu_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid, req_rd_fp, flush, in_rdy, out_vld, wb_ready, fclr;
  logic [4:0]  req_rd, sts;
  logic [31:0] res;

  logic        req_ready, wb_valid, wb_rd_fp, busy, timeout;
  logic [4:0]  wb_rd, fflags;
  logic [31:0] wb_data;
  logic        w_req_ready, w_wb_valid, w_wb_rd_fp, w_busy, w_timeout;
  logic [4:0]  w_wb_rd, w_fflags;
  logic [31:0] w_wb_data;

  cve2_fpu_issue_ctrl_if #(.FlagsW(5)) f0 ();
  cve2_fpu_issue_ctrl_if #(.FlagsW(5)) f1 ();
  assign f0.in_ready  = in_rdy;
  assign f0.out_valid = out_vld;
  assign f0.result    = res;
  assign f0.status    = sts;
  assign f1.in_ready  = in_rdy;
  assign f1.out_valid = out_vld;
  assign f1.result    = res;
  assign f1.status    = sts;

  cve2_fpu_issue_ctrl #(.TimeoutCycles(64), .FlagsW(5)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rd_i(req_rd), .req_rd_fp_i(req_rd_fp),
    .flush_i(flush), .fpu(f0),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_rd_o(wb_rd), .wb_rd_fp_o(wb_rd_fp),
    .wb_data_o(wb_data), .fflags_o(fflags), .fflags_clr_i(fclr), .busy_o(busy), .timeout_o(timeout)
  );

  cve2_fpu_issue_ctrl #(.TimeoutCycles(4), .FlagsW(5)) u_wd (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(w_req_ready), .req_rd_i(req_rd), .req_rd_fp_i(req_rd_fp),
    .flush_i(flush), .fpu(f1),
    .wb_valid_o(w_wb_valid), .wb_ready_i(wb_ready), .wb_rd_o(w_wb_rd), .wb_rd_fp_o(w_wb_rd_fp),
    .wb_data_o(w_wb_data), .fflags_o(w_fflags), .fflags_clr_i(fclr), .busy_o(w_busy),
    .timeout_o(w_timeout)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic        fp;
    logic [31:0] data;
  } wb_exp_t;
  wb_exp_t sb[$];
  wb_exp_t e;

  function automatic void push(input logic [4:0] rd, input logic fp, input logic [31:0] data);
    wb_exp_t x;
    x.rd = rd; x.fp = fp; x.data = data;
    sb.push_back(x);
  endfunction

  // Writeback monitor on the main instance: every accepted writeback pops one expectation.
  always @(negedge clk) begin
    if (rst_n && wb_valid && wb_ready) begin
      if (sb.size() == 0) chk("wb_unexpected", 64'(wb_rd), 64'h1_0000);
      else begin
        e = sb.pop_front();
        chk("wb_rd", 64'(wb_rd), 64'(e.rd));
        chk("wb_rd_fp", 64'(wb_rd_fp), 64'(e.fp));
        chk("wb_data", 64'(wb_data), 64'(e.data));
      end
    end
  end

  task automatic nx();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] rd, input logic fp);
    req_valid = 1'b1; req_rd = rd; req_rd_fp = fp;
    smp();
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    nx();
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 0; req_rd = 0; req_rd_fp = 0; flush = 0;
    in_rdy = 0; out_vld = 0; res = 0; sts = 0; wb_ready = 0; fclr = 0;
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_valid", 64'(f0.in_valid), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_fflags", 64'(fflags), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Combinational FPU: accept -> wb_valid two cycles later
    in_rdy = 1; out_vld = 1; res = 32'h3f80_0000; sts = 5'b00001; wb_ready = 1;
    push(5'd7, 1'b1, 32'h3f80_0000);
    issue(5'd7, 1'b1);
    smp(); chk("c_in_valid", 64'(f0.in_valid), 64'd1); chk("c_wb_early", 64'(wb_valid), 64'd0);
    nx();
    smp(); chk("c_wb_valid_cyc2", 64'(wb_valid), 64'd1); chk("c_wb_rd_cyc2", 64'(wb_rd), 64'd7);
    nx(); out_vld = 0;
    smp(); chk("c_fflags", 64'(fflags), 64'd1); chk("c_busy", 64'(busy), 64'd0);
    nx();

    // in_ready held low for three cycles
    in_rdy = 0;
    issue(5'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      smp(); chk("s_in_valid_hold", 64'(f0.in_valid), 64'd1); chk("s_req_ready", 64'(req_ready), 64'd0);
      nx();
    end
    in_rdy = 1;
    smp(); chk("s_in_valid_4th", 64'(f0.in_valid), 64'd1);
    nx(); in_rdy = 0;
    smp(); chk("s_wait_in_valid", 64'(f0.in_valid), 64'd0); chk("s_wait_out_ready", 64'(f0.out_ready), 64'd1);
    out_vld = 1; res = 32'h4049_0fdb; sts = 5'b00100;
    push(5'd3, 1'b0, 32'h4049_0fdb);
    nx(); out_vld = 0;
    smp(); chk("s_wb_valid", 64'(wb_valid), 64'd1);
    nx();
    smp(); chk("s_fflags", 64'(fflags), 64'd5);

    // Long divide with writeback backpressure
    nx();
    in_rdy = 1; out_vld = 0; wb_ready = 0;
    issue(5'd9, 1'b1);
    nx(); in_rdy = 0;
    for (int i = 0; i < 9; i++) nx();
    out_vld = 1; res = 32'hc000_0000; sts = 5'b01000;
    push(5'd9, 1'b1, 32'hc000_0000);
    smp(); chk("d_busy", 64'(busy), 64'd1); chk("d_wb_early", 64'(wb_valid), 64'd0);
    nx(); out_vld = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) wb_ready = 1;
      smp(); chk("d_wb_valid_stall", 64'(wb_valid), 64'd1); chk("d_wb_data_stable", 64'(wb_data), 64'hc000_0000);
      nx();
    end
    smp(); chk("d_fflags", 64'(fflags), 64'd13); chk("d_busy_done", 64'(busy), 64'd0);

    // Flush in WAIT: single flush pulse, late result ignored
    nx();
    in_rdy = 1; out_vld = 0;
    issue(5'd4, 1'b0);
    nx(); in_rdy = 0;
    nx(); nx();
    flush = 1;
    smp(); chk("f_flush_pulse", 64'(f0.flush), 64'd1); chk("f_req_ready", 64'(req_ready), 64'd0);
    nx(); flush = 0; out_vld = 1; res = 32'hdead_beef; sts = 5'b10000;
    smp(); chk("f_flush_once", 64'(f0.flush), 64'd0); chk("f_idle", 64'(busy), 64'd0);
    chk("f_no_wb", 64'(wb_valid), 64'd0);
    nx(); out_vld = 0;
    smp(); chk("f_no_wb_late", 64'(wb_valid), 64'd0); chk("f_fflags", 64'(fflags), 64'd13);

    // Watchdog (4 cycles) expiry on the short-timeout instance
    nx();
    in_rdy = 1; out_vld = 0;
    issue(5'd5, 1'b0);
    nx(); in_rdy = 0;
    for (int k = 1; k <= 4; k++) begin
      smp();
      chk("t_timeout", 64'(w_timeout), 64'(k == 4));
      chk("t_flush", 64'(f1.flush), 64'(k == 4));
      nx();
    end
    smp(); chk("t_busy_after", 64'(w_busy), 64'd0); chk("t_main_busy", 64'(busy), 64'd1);
    flush = 1;
    nx(); flush = 0;

    // out_valid on the last watchdog cycle wins over the timeout
    in_rdy = 1;
    issue(5'd6, 1'b1);
    nx(); in_rdy = 0;
    nx(); nx(); nx();
    out_vld = 1; res = 32'h1234_5678; sts = 5'b00000;
    push(5'd6, 1'b1, 32'h1234_5678);
    smp(); chk("tb_no_timeout", 64'(w_timeout), 64'd0); chk("tb_no_flush", 64'(f1.flush), 64'd0);
    nx(); out_vld = 0;
    smp(); chk("tb_wd_wb", 64'(w_wb_valid), 64'd1); chk("tb_wb", 64'(wb_valid), 64'd1);
    nx();
    smp(); chk("tb_wd_idle", 64'(w_busy), 64'd0);

    // Flush while holding a result in WB discards it
    nx();
    in_rdy = 1; out_vld = 1; res = 32'haaaa_5555; sts = 5'b00010; wb_ready = 0;
    issue(5'd8, 1'b0);
    nx();
    flush = 1;
    smp(); chk("w_wb_valid", 64'(wb_valid), 64'd1);
    nx(); flush = 0;
    smp(); chk("w_discard", 64'(wb_valid), 64'd0); chk("w_fflags", 64'(fflags), 64'd13);
    chk("w_idle", 64'(busy), 64'd0);

    // fflags clear alone, then clear coincident with an accumulate
    nx();
    in_rdy = 0; out_vld = 0; wb_ready = 1; fclr = 1;
    nx(); fclr = 0;
    smp(); chk("g_clr", 64'(fflags), 64'd0);
    nx();
    in_rdy = 1; out_vld = 1; res = 32'h1; sts = 5'b10000;
    push(5'd1, 1'b0, 32'h1);
    issue(5'd1, 1'b0);
    nx(); nx();
    smp(); chk("g_set", 64'(fflags), 64'h10);
    nx();
    res = 32'h2; sts = 5'b00010;
    push(5'd2, 1'b1, 32'h2);
    issue(5'd2, 1'b1);
    nx(); fclr = 1;
    smp(); chk("g_wb_valid", 64'(wb_valid), 64'd1);
    nx(); fclr = 0;
    smp(); chk("g_clr_acc", 64'(fflags), 64'h02);

    // Flush in IDLE blocks acceptance
    nx();
    out_vld = 0; flush = 1; req_valid = 1; req_rd = 5'd12;
    smp(); chk("i_req_ready_flush", 64'(req_ready), 64'd0);
    nx(); req_valid = 0; flush = 0;
    smp(); chk("i_not_accepted", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of WAIT
    nx();
    in_rdy = 1; out_vld = 0;
    issue(5'd11, 1'b1);
    nx(); in_rdy = 0;
    nx();
    #2 rst_n = 1'b0;
    #1;
    chk("r_busy", 64'(busy), 64'd0);
    chk("r_req_ready", 64'(req_ready), 64'd1);
    chk("r_in_valid", 64'(f0.in_valid), 64'd0);
    chk("r_out_ready", 64'(f0.out_ready), 64'd0);
    chk("r_flush", 64'(f0.flush), 64'd0);
    chk("r_wb_valid", 64'(wb_valid), 64'd0);
    chk("r_timeout", 64'(timeout), 64'd0);
    chk("r_fflags", 64'(fflags), 64'd0);
    chk("r_wb_rd", 64'(wb_rd), 64'd0);
    chk("r_wb_data", 64'(wb_data), 64'd0);
    nx(); rst_n = 1'b1;
    smp(); chk("r_idle_after", 64'(busy), 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
